// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared FSM state type and default parameters for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;
  localparam int TIMEOUT_DEF    = 2048;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select: first valid index strictly after ptr, wrapping
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  int            cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // NUM_REQ need not be a power of two, so the wrap is a compare-and-subtract
  always_comb begin
    any      = |valid;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, burst-limited scheduler sharing one uart_tx between requesters
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MAX_BURST      = MAX_BURST_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] PTR_RESET = GW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [WW-1:0]         wd_cnt_q, wd_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic [GW-1:0]         pick_idx, winner;
  logic                  pick_any, cont;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  timeout_c;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    tx_data_d   = tx_data_q;
    ready_c     = '0;
    timeout_c   = 1'b0;
    // burst_cnt of zero means no live burst (after reset, timeout or a dropped valid)
    cont   = (burst_cnt_q != '0) && (burst_cnt_q < BURST_MAX) && req_valid[grant_id_q];
    winner = cont ? grant_id_q : pick_idx;

    unique case (state_q)
      IDLE: begin
        if (!req_valid[grant_id_q]) burst_cnt_d = '0;
        if (pick_any) begin
          ready_c[winner] = 1'b1;
          tx_data_d       = req_bytes[winner];
          grant_id_d      = winner;
          rr_ptr_d        = winner;
          burst_cnt_d     = cont ? burst_cnt_q + BW'(1) : BW'(1);
          state_d         = START;
        end
      end
      START: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_c   = 1'b1;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PTR_RESET;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      wd_cnt_q    <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // strobes are forced low while reset is held so nothing is accepted or started
  assign req_ready   = reset ? '0 : ready_c;
  assign tx_start    = !reset && (state_q == START);
  assign timeout_err = !reset && timeout_c;
  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;

endmodule
